key_debounce: RTL and testbench

//  Front-end conditioner for the DE10-Lite push-buttons (KEY, active-low, bouncy, asynchronous).
//  Per key: 2-flop synchronizer, debounce counter/FSM, clean active-high level, one-cycle press/release pulses.

---
 rtl/key_debounce_if.sv | 29 ++
 rtl/key_debounce.sv | 179 +++++++++++++++++
 tb/tb_key_debounce.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Key bus between raw push-buttons and their conditioned outputs.
//   key_n       : raw active-low buttons (0 = pressed), asynchronous
//   key_level   : debounced state, active-high
//   key_press   : one-cycle pulse on an accepted press
//   key_release : one-cycle pulse on an accepted release
// master: drives key_n and observes the conditioned outputs (board/bench side)
// slave : the debouncer
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 2
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: for each key a 2-flop synchronizer, a debounce
// FSM/counter, a clean active-high level and one-cycle press/release pulses.
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active-low
//   bus   : key_debounce_if.slave (key_n in; key_level/key_press/key_release out)
// Optional feature: define KEY_AUTOREPEAT_EN for extra key_press pulses while a
// key stays held (first after REPEAT_DLY_US, then every REPEAT_PER_US).
module key_debounce #(
  parameter int unsigned N_KEYS        = 2,
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned DEBOUNCE_US   = 10_000,
  parameter int unsigned REPEAT_DLY_US = 500_000,
  parameter int unsigned REPEAT_PER_US = 100_000
) (
  input logic           clk,
  input logic           rst_n,
  key_debounce_if.slave bus
);

  localparam int unsigned CLK_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned DB_CYCLES  = CLK_PER_US * DEBOUNCE_US;
  localparam int unsigned CNT_W      = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce: DB_CYCLES must be at least 2");
  end
  if (REPEAT_DLY_US == 0 || REPEAT_PER_US == 0) begin : g_bad_repeat
    $error("key_debounce: repeat timings must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic [N_KEYS-1:0] s1_q, s1_d;
  logic [N_KEYS-1:0] s2_q, s2_d;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] rel_q, rel_d;
  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_DLY_CYCLES = CLK_PER_US * REPEAT_DLY_US;
  localparam int unsigned RPT_PER_CYCLES = CLK_PER_US * REPEAT_PER_US;
  localparam int unsigned RPT_MAX = (RPT_DLY_CYCLES > RPT_PER_CYCLES) ?
                                    RPT_DLY_CYCLES : RPT_PER_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX) + 1;

  logic [RPT_W-1:0]  rpt_q [N_KEYS];
  logic [RPT_W-1:0]  rpt_d [N_KEYS];
  // Set once the initial delay has elapsed; later repeats use the period.
  logic [N_KEYS-1:0] first_q, first_d;
`endif

  always_comb begin
    s1_d    = bus.key_n;
    s2_d    = s1_q;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
    first_d = '0;
`endif
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef KEY_AUTOREPEAT_EN
      // Timer is zero in every state except a steady PRESSED.
      rpt_d[i]   = '0;
`endif
      unique case (state_q[i])
        IDLE: begin
          if (!s2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end else begin
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (s2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (s2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end else begin
`ifdef KEY_AUTOREPEAT_EN
            first_d[i] = first_q[i];
            if (rpt_q[i] == (first_q[i] ? RPT_W'(RPT_PER_CYCLES - 1)
                                        : RPT_W'(RPT_DLY_CYCLES - 1))) begin
              press_d[i] = 1'b1;
              first_d[i] = 1'b1;
            end else begin
              rpt_d[i]   = rpt_q[i] + RPT_W'(1);
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (!s2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '1;
      s2_q    <= '1;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
`ifdef KEY_AUTOREPEAT_EN
      first_q <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        rpt_q[i] <= '0;
      end
`endif
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
`ifdef KEY_AUTOREPEAT_EN
      first_q <= first_d;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        rpt_q[i] <= rpt_d[i];
      end
`endif
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = rel_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES = 8 (1 MHz, 8 us),
// repeat delay 40 cycles and period 16 cycles.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  key_debounce_if #(.N_KEYS(2)) kif ();

  key_debounce #(
    .N_KEYS        (2),
    .CLK_FREQ_HZ   (1_000_000),
    .DEBOUNCE_US   (8),
    .REPEAT_DLY_US (40),
    .REPEAT_PER_US (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  acc_p;
  logic [1:0]  acc_r;
  int unsigned n_press;
  logic        exp_rpt;

  initial begin
    rst_n     = 1'b0;
    kif.key_n = 2'b00;

    // Reset with both keys held: outputs quiet, fresh press 10 cycles after release.
    step(3);
    check("rst_level",   32'(kif.key_level),   32'h0);
    check("rst_press",   32'(kif.key_press),   32'h0);
    check("rst_release", 32'(kif.key_release), 32'h0);
    rst_n = 1'b1;
    step(9);
    check("rst_hold_press_c9",  32'(kif.key_press), 32'h0);
    step(1);
    check("rst_hold_press_c10", 32'(kif.key_press), 32'h3);
    check("rst_hold_level_c10", 32'(kif.key_level), 32'h3);
    step(1);
    check("rst_hold_press_c11", 32'(kif.key_press), 32'h0);

    // Release both.
    kif.key_n = 2'b11;
    step(9);
    check("rel_both_level_c9",  32'(kif.key_level),   32'h3);
    step(1);
    check("rel_both_rel_c10",   32'(kif.key_release), 32'h3);
    check("rel_both_level_c10", 32'(kif.key_level),   32'h0);
    step(1);
    check("rel_both_rel_c11",   32'(kif.key_release), 32'h0);

    // Clean press on key 0.
    kif.key_n = 2'b10;
    step(9);
    check("press0_c9",        32'(kif.key_press), 32'h0);
    step(1);
    check("press0_c10",       32'(kif.key_press), 32'h1);
    check("press0_level_c10", 32'(kif.key_level), 32'h1);
    check("press0_rel_c10",   32'(kif.key_release), 32'h0);
    step(1);
    check("press0_c11",       32'(kif.key_press), 32'h0);

    // 7-cycle release glitch while pressed: no release.
    kif.key_n = 2'b11;
    step(7);
    kif.key_n = 2'b10;
    acc_r = 2'b00;
    for (int c = 0; c < 20; c++) begin
      step(1);
      acc_r |= kif.key_release;
    end
    check("glitch_no_release", 32'(acc_r),         32'h0);
    check("glitch_level",      32'(kif.key_level), 32'h1);

    // Clean release of key 0.
    kif.key_n = 2'b11;
    step(9);
    check("release0_c9",       32'(kif.key_release), 32'h0);
    step(1);
    check("release0_c10",      32'(kif.key_release), 32'h1);
    check("release0_level",    32'(kif.key_level),   32'h0);
    step(1);
    check("release0_c11",      32'(kif.key_release), 32'h0);

    // Bounce: low 5, high 2, then steady low; one press 10 after last fall.
    n_press   = 0;
    kif.key_n = 2'b10;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (kif.key_press[0]) n_press++;
    end
    kif.key_n = 2'b11;
    for (int c = 0; c < 2; c++) begin
      step(1);
      if (kif.key_press[0]) n_press++;
    end
    kif.key_n = 2'b10;
    for (int c = 0; c < 9; c++) begin
      step(1);
      if (kif.key_press[0]) n_press++;
    end
    check("bounce_early_presses", n_press, 32'd0);
    step(1);
    check("bounce_press_c10", 32'(kif.key_press), 32'h1);
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (kif.key_press[0]) n_press++;
    end
    check("bounce_no_extra", n_press, 32'd0);
    kif.key_n = 2'b11;
    step(12);
    check("bounce_released", 32'(kif.key_level), 32'h0);

    // Simultaneous press of both keys.
    kif.key_n = 2'b00;
    step(9);
    check("simul_c9",  32'(kif.key_press), 32'h0);
    step(1);
    check("simul_c10", 32'(kif.key_press), 32'h3);
    kif.key_n = 2'b11;
    step(12);
    check("simul_released", 32'(kif.key_level), 32'h0);

    // Reset at cycle 6 of a debounce aborts it.
    kif.key_n = 2'b00;
    step(6);
    rst_n = 1'b0;
    acc_p = 2'b00;
    for (int c = 0; c < 8; c++) begin
      step(1);
      acc_p |= kif.key_press;
    end
    check("abort_no_press", 32'(acc_p),         32'h0);
    check("abort_level",    32'(kif.key_level), 32'h0);
    kif.key_n = 2'b11;
    rst_n     = 1'b1;
    acc_p = 2'b00;
    acc_r = 2'b00;
    for (int c = 0; c < 12; c++) begin
      step(1);
      acc_p |= kif.key_press;
      acc_r |= kif.key_release;
    end
    check("abort_after_press",   32'(acc_p),         32'h0);
    check("abort_after_release", 32'(acc_r),         32'h0);
    check("abort_after_level",   32'(kif.key_level), 32'h0);

    // Hold key 1 for 100 cycles.
    kif.key_n = 2'b01;
    for (int c = 1; c <= 100; c++) begin
      step(1);
      exp_rpt = (c == 10);
`ifdef KEY_AUTOREPEAT_EN
      exp_rpt = exp_rpt || (c == 50) || (c == 66) || (c == 82) || (c == 98);
`endif
      check($sformatf("hold1_press_c%0d", c), 32'(kif.key_press[1]), 32'(exp_rpt));
    end
    check("hold1_level", 32'(kif.key_level), 32'h2);
    kif.key_n = 2'b11;
    step(10);
    check("hold1_release", 32'(kif.key_release), 32'h2);
    check("hold1_level_off", 32'(kif.key_level), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
